cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//   Fetch/execute sequencer for the 4-register 8-bit datapath. Holds a small
//   program RAM loaded over a write port and steps a program counter. Presents
//   one instruction at a time to the datapath (opcode[7:4], dst[3:2], src[1:0])
//   with a one-cycle execute strobe.
//   Replaces hand-fed DIP instructions; supports free-run, single-step (button),
//   jump and halt.
// PARAMETERS
//   ADDR_W  4            program address width; depth = 2**ADDR_W words
//   INSTR_W 8            instruction width (fixed 8 for current datapath)
// PORTS
//   clk        in   1        system clock (50 MHz)
//   rst        in   1        reset, asynchronous, active-low
//   restart    in   1        1-cycle pulse: pc<=0, go IDLE, clear halt
//   load_we    in   1        program write enable (honoured in IDLE/HALT only)
//   load_addr  in   ADDR_W   program write address
//   load_data  in   INSTR_W  program write data
//   run        in   1        level: free-run while high
//   step       in   1        1-cycle pulse (debounced button): execute one instr
//   pc         out  ADDR_W   current program counter
//   instr      out  INSTR_W  instruction presented to datapath
//   exec       out  1        1-cycle strobe: datapath executes instr this cycle
//   busy       out  1        high in FETCH or EXEC
//   halted     out  1        high in HALT
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, pc=0, instr=0, exec=0, busy=0, halted=0,
//     step_mode=0. Program RAM is not reset; contents survive rst. RAM
//     initialises to 0x00 (NOP) at configuration.
//   States: IDLE, FETCH, EXEC, HALT. All registered outputs.
//   IDLE: run=1 -> FETCH, step_mode=0; else step=1 -> FETCH, step_mode=1.
//     run and step together: run wins.
//   FETCH (1 cycle): instr <= mem[pc]; -> EXEC.
//   EXEC (1 cycle), decode instr[7:4]:
//     0x0-0xD: exec=1; pc <= pc+1, wrapping 2**ADDR_W-1 -> 0.
//     0xE JMP: exec=0; pc <= instr[ADDR_W-1:0].
//     0xF HALT: exec=0; pc unchanged; -> HALT.
//     Non-halt next state: step_mode=1 -> IDLE; run=1 -> FETCH; else IDLE.
//   Throughput: one instruction per 2 clocks in free-run. exec asserts in the
//     2nd cycle after FETCH entry; instr is stable throughout EXEC.
//   HALT: halted=1; ignores run/step; exits only via restart or rst.
//   restart: highest priority in any state. pc<=0, exec forced 0, -> IDLE,
//     halted=0; an in-flight EXEC is aborted (no strobe).
//   Priority: rst > restart > load_we > run/step.
//   load_we: writes mem[load_addr] only in IDLE or HALT; ignored while busy.
//   step pulses outside IDLE are dropped (not queued).
//   run dropped mid-instruction: the current EXEC completes, then -> IDLE.
// TESTING
//   Free-run: mem[0..2]={0x15,0x1D,0xF0}, run=1 -> exactly 2 exec strobes with
//     instr 0x15 then 0x1D, 2 clks apart; then halted=1, pc=2, busy=0.
//   Single-step: mem[0..1]={0x00,0x25}, step pulse -> one exec (instr 0x00),
//     pc=1, IDLE; second pulse -> exec with 0x25, pc=2; extra pulses while busy
//     are ignored.
//   Jump: mem[0]=0xE3, mem[3]=0xF0, run=1 -> zero exec strobes, pc 0->3,
//     halted=1, pc=3.
//   Wrap: all 16 words 0x10, run=1 for 40 clks -> exec every 2nd clk, pc goes
//     15->0 without a stall.
//   Reset/restart: rst=0 during EXEC -> exec/busy/pc drop to 0 immediately,
//     RAM intact after release. restart in HALT -> halted=0, pc=0, IDLE.
//     load_we while busy leaves RAM unchanged.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - program load, control and instruction-presentation bundle for cpu_sequencer
interface cpu_sequencer_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
);
    logic               restart;
    logic               load_we;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               run;
    logic               step;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               exec;
    logic               busy;
    logic               halted;

    modport master (
        output restart, load_we, load_addr, load_data, run, step,
        input  pc, instr, exec, busy, halted
    );

    modport slave (
        input  restart, load_we, load_addr, load_data, run, step,
        output pc, instr, exec, busy, halted
    );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/execute sequencer with loadable program RAM, free-run, single-step, jump and halt
module cpu_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               exec_q, exec_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic               step_mode_q, step_mode_d;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] mem_rd;
    logic [3:0]         fetch_op;
    logic [3:0]         exec_op;
    logic               mem_we;

    assign mem_rd   = mem[pc_q];
    assign fetch_op = mem_rd[INSTR_W-1 -: 4];
    assign exec_op  = instr_q[INSTR_W-1 -: 4];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        exec_d      = 1'b0;
        step_mode_d = step_mode_q;
        mem_we      = 1'b0;

        if (bus.restart) begin
            state_d     = S_IDLE;
            pc_d        = '0;
            step_mode_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.load_we) begin
                        mem_we = 1'b1;
                    end else if (bus.run) begin
                        state_d     = S_FETCH;
                        step_mode_d = 1'b0;
                    end else if (bus.step) begin
                        state_d     = S_FETCH;
                        step_mode_d = 1'b1;
                    end
                end
                // Strobe is decided here so exec is a flop aligned with instr in EXEC.
                S_FETCH: begin
                    instr_d = mem_rd;
                    exec_d  = (fetch_op < 4'hE);
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    case (exec_op)
                        4'hE:    pc_d = instr_q[ADDR_W-1:0];
                        4'hF:    pc_d = pc_q;
                        default: pc_d = pc_q + ADDR_W'(1);
                    endcase
                    if (exec_op == 4'hF)
                        state_d = S_HALT;
                    else if (!step_mode_q && bus.run)
                        state_d = S_FETCH;
                    else
                        state_d = S_IDLE;
                end
                S_HALT: begin
                    mem_we = bus.load_we;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            exec_q      <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            step_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            exec_q      <= exec_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            step_mode_q <= step_mode_d;
        end
    end

    // Program contents deliberately survive rst.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[bus.load_addr] <= bus.load_data;
    end

    assign bus.pc     = pc_q;
    assign bus.instr  = instr_q;
    assign bus.exec   = exec_q;
    assign bus.busy   = busy_q;
    assign bus.halted = halted_q;
endmodule
